bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter Bus_length, default 32, SHALL set the number of bus requesters/drivers.
REQ-002 Parameter Bus_width, default 32, SHALL set the bus data width.
REQ-003 Parameter Max_hold, default 4, SHALL set the maximum tenure in cycles, with a legal range of 1..255.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port req, input, [Bus_length-1:0]: per-driver bus request.
REQ-008 Port bus_in, input, signed [Bus_width-1:0]: the resolved tri-state bus value.
REQ-009 Port sel_lines, output, [Bus_length-1:0]: one-hot or zero driver enables feeding the bus.
REQ-010 Port grant_valid, output, 1 bit: high whenever sel_lines is non-zero.
REQ-011 Port owner_id, output, [$clog2(Bus_length)-1:0]: index of the current owner; 0 when idle.
REQ-012 Port bus_data_q, output, signed [Bus_width-1:0]: last captured bus value.
REQ-013 Port capture_valid, output, 1 bit: one-cycle pulse per new bus_data_q value.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, GRANT and HOLD, all registered.
REQ-015 IDLE: if req is non-zero, the FSM SHALL pick the winner round-robin, scanning upward from (last_owner+1) mod Bus_length, then go to GRANT; otherwise it SHALL stay in IDLE.
REQ-016 Latency: req sampled high at edge n SHALL give registered sel_lines one-hot at the winner from edge n+1.
REQ-017 sel_lines SHALL never have more than one bit set, and SHALL be zero in IDLE.
REQ-018 GRANT SHALL last exactly one cycle, then go to HOLD if req[owner] is high and Max_hold>1; otherwise it SHALL go to IDLE.
REQ-019 HOLD SHALL stay in HOLD while req[owner] is high and the tenure counter is below Max_hold; otherwise it SHALL go to IDLE.
REQ-020 The tenure counter SHALL load 1 on entry to GRANT and increment in each HOLD cycle.
REQ-021 Every owner transition SHALL pass through IDLE, giving one dead cycle with sel_lines=0 so two drivers are never enabled back-to-back.
REQ-022 In each GRANT or HOLD cycle, bus_in SHALL be registered into bus_data_q at the closing edge, with capture_valid high for the following cycle.
REQ-023 last_owner SHALL update to the winner on entry to GRANT.
REQ-024 Owner drops req during GRANT: the single capture SHALL still occur, then the FSM SHALL go to IDLE.
REQ-025 Tenure expiry with the owner still requesting and no other requester: after the IDLE dead cycle, the same owner SHALL be re-granted.
REQ-026 All requesters active: grants SHALL rotate 0,1,2,... with no starvation; worst-case wait is Bus_length*(Max_hold+1) cycles.
REQ-027 Changes to req bits other than the owner's SHALL have no effect during GRANT/HOLD.

Reset
REQ-028 While rst is high at an edge, the block SHALL set state=IDLE, sel_lines=0, grant_valid=0, owner_id=0, bus_data_q=0, capture_valid=0, tenure=0, and last_owner=Bus_length-1, so that index 0 has first priority.
REQ-029 Reset asserted mid-tenure SHALL drop sel_lines to 0 at that edge, with no capture on that edge.
REQ-030 The first arbitration SHALL occur on the first edge with rst low.

Structure
REQ-031 A shared package bus_pkg SHALL hold the state enum (IDLE/GRANT/HOLD) and the default Bus_length/Bus_width constants also used by bus.
REQ-032 The block SHALL contain one sub-module, rr_pick, which is combinational: it maps the req vector and last_owner to a one-hot winner and winner index.
REQ-033 The total RTL SHALL be 120-400 lines.

Verification
REQ-034 Scenario: rst for 2 cycles, then req='b0001 with driver0=13 -> sel_lines='b0001 one cycle later, then bus_data_q=13 with a capture_valid pulse.
REQ-035 Scenario: req='b1111 held, Max_hold=4, data 13/3/2432/31123 -> owners 0,1,2,3,0,...; each tenure is 4 cycles plus 1 dead cycle; bus_data_q shows each value in turn.
REQ-036 Scenario: req[2] pulsed for one cycle only -> exactly one GRANT cycle, one capture of 2432, then IDLE.
REQ-037 Scenario: req='b1000 held alone -> grant to 3 for 4 cycles, 1 dead cycle, then re-grant to 3.
REQ-038 Scenario: rst asserted during the HOLD of owner 1 -> sel_lines=0 and bus_data_q=0 at that edge; the next grant goes to the lowest requesting index.
REQ-039 Every scenario SHALL include an assertion that $onehot0(sel_lines) holds every cycle and that no cycle has both the old and the new owner selected.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter slice.
// Holds the arbiter state encoding, the default bus geometry used by the
// arbiter and by the bus interface, and a helper for index-field widths.
package bus_pkg;

  localparam int BUS_LENGTH_DEF = 32;
  localparam int BUS_WIDTH_DEF  = 32;
  localparam int MAX_HOLD_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  // Width of an index into n requesters; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface.
// Groups the requester/bus side signals of the arbiter:
//   req           - per-driver bus request
//   bus_in        - resolved tri-state bus value
//   sel_lines     - one-hot-or-zero driver enables
//   grant_valid   - high whenever sel_lines is non-zero
//   owner_id      - index of the current owner, 0 when idle
//   bus_data_q    - last captured bus value
//   capture_valid - one-cycle pulse per new bus_data_q value
// master: the arbiter side; slave: the requesters/drivers side.
interface bus_arbiter_if import bus_pkg::*; #(
  parameter int Bus_length = BUS_LENGTH_DEF,
  parameter int Bus_width  = BUS_WIDTH_DEF
) ();

  localparam int Id_w = id_width(Bus_length);

  logic        [Bus_length-1:0] req;
  logic signed [Bus_width-1:0]  bus_in;
  logic        [Bus_length-1:0] sel_lines;
  logic                         grant_valid;
  logic        [Id_w-1:0]       owner_id;
  logic signed [Bus_width-1:0]  bus_data_q;
  logic                         capture_valid;

  modport master (
    input  req, bus_in,
    output sel_lines, grant_valid, owner_id, bus_data_q, capture_valid
  );

  modport slave (
    output req, bus_in,
    input  sel_lines, grant_valid, owner_id, bus_data_q, capture_valid
  );

endinterface

// File: rtl/bus_arbiter_chk.sv
// Safety checker for the arbiter driver enables.
// Ports:
//   clk, rst  - arbiter clock and synchronous reset
//   sel_lines - driver enables to be checked
// Ensures at most one driver is enabled and that a select can only be
// followed by the same select or by a dead (all-zero) cycle.
module bus_arbiter_chk import bus_pkg::*; #(
  parameter int N = BUS_LENGTH_DEF
) (
  input logic         clk,
  input logic         rst,
  input logic [N-1:0] sel_lines
);

  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(sel_lines));

  a_no_handover: assert property (@(posedge clk) disable iff (rst)
    ((|$past(sel_lines)) && (|sel_lines)) |-> (sel_lines == $past(sel_lines)));

endmodule

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner selection (combinational).
// Ports:
//   req           - request vector
//   last_owner    - index of the most recent owner
//   winner_onehot - one-hot winner, zero when nothing is requested
//   winner_idx    - index of the winner, zero when nothing is requested
//   winner_valid  - at least one request present
// The scan starts at (last_owner+1) mod N and moves upward, wrapping to 0.
module rr_pick import bus_pkg::*; #(
  parameter int N  = BUS_LENGTH_DEF,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  winner_onehot,
  output logic [IW-1:0] winner_idx,
  output logic          winner_valid
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] upto_last_s;
  logic [N-1:0] above_s;
  logic [N-1:0] src_s;

  // Bits strictly above last_owner; when last_owner is the top index the
  // shift overflows to zero and the mask becomes empty, forcing the wrap.
  assign upto_last_s = ((ONE << last_owner) << 1) - ONE;
  assign above_s     = req & ~upto_last_s;

  // Prefer requesters above last_owner, otherwise wrap to the full vector
  always_comb begin
    if (|above_s) begin
      src_s = above_s;
    end else begin
      src_s = req;
    end
  end

  // Isolate the lowest set bit of the chosen source
  assign winner_onehot = src_s & (~src_s + ONE);
  assign winner_valid  = |req;

  // Encode the one-hot winner into an index
  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (winner_onehot[i]) begin
        winner_idx = IW'(i);
      end else begin
        winner_idx = winner_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tri-state bus arbiter.
// Grants one driver at a time, holds the grant for up to Max_hold cycles
// (legal range 1..255) while the owner keeps requesting, captures the bus
// value on every owned cycle and inserts one dead cycle between tenures.
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - bus_arbiter_if master modport (req, bus_in in; sel_lines,
//         grant_valid, owner_id, bus_data_q, capture_valid out)
module bus_arbiter import bus_pkg::*; #(
  parameter int Bus_length = BUS_LENGTH_DEF,
  parameter int Bus_width  = BUS_WIDTH_DEF,
  parameter int Max_hold   = MAX_HOLD_DEF
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.master bus
);

  localparam int              Id_w     = id_width(Bus_length);
  localparam logic [Id_w-1:0] LAST_RST = Id_w'(Bus_length - 1);
  localparam logic [7:0]      HOLD_MAX = 8'(Max_hold);

  arb_state_t                  state_r;
  logic        [Bus_length-1:0] sel_r;
  logic                         grant_valid_r;
  logic        [Id_w-1:0]       owner_r;
  logic        [Id_w-1:0]       last_owner_r;
  logic        [7:0]            tenure_r;
  logic signed [Bus_width-1:0]  data_r;
  logic                         capture_r;

  logic [Bus_length-1:0] pick_onehot_s;
  logic [Id_w-1:0]       pick_idx_s;
  logic                  pick_valid_s;
  logic                  owner_req_s;
  logic                  keep_s;

  rr_pick #(
    .N  (Bus_length),
    .IW (Id_w)
  ) u_rr_pick (
    .req           (bus.req),
    .last_owner    (last_owner_r),
    .winner_onehot (pick_onehot_s),
    .winner_idx    (pick_idx_s),
    .winner_valid  (pick_valid_s)
  );

  // The owner's request bit is the one under the current one-hot select;
  // requests from anyone else are ignored while a tenure is running.
  assign owner_req_s = |(bus.req & sel_r);
  // Tenure is 1 during GRANT, so this also covers "GRANT -> HOLD only if
  // Max_hold > 1".
  assign keep_s      = owner_req_s && (tenure_r < HOLD_MAX);

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      sel_r         <= '0;
      grant_valid_r <= 1'b0;
      owner_r       <= '0;
      last_owner_r  <= LAST_RST;
      tenure_r      <= 8'd0;
      data_r        <= '0;
      capture_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          capture_r <= 1'b0;
          if (pick_valid_s) begin
            state_r       <= GRANT;
            sel_r         <= pick_onehot_s;
            grant_valid_r <= 1'b1;
            owner_r       <= pick_idx_s;
            last_owner_r  <= pick_idx_s;
            tenure_r      <= 8'd1;
          end else begin
            state_r       <= IDLE;
            sel_r         <= '0;
            grant_valid_r <= 1'b0;
            owner_r       <= '0;
            tenure_r      <= 8'd0;
          end
        end
        GRANT, HOLD: begin
          // Every owned cycle captures the bus at its closing edge
          data_r    <= bus.bus_in;
          capture_r <= 1'b1;
          if (keep_s) begin
            state_r  <= HOLD;
            tenure_r <= tenure_r + 8'd1;
          end else begin
            // Always release through IDLE to give the dead cycle
            state_r       <= IDLE;
            sel_r         <= '0;
            grant_valid_r <= 1'b0;
            owner_r       <= '0;
            tenure_r      <= 8'd0;
          end
        end
        default: begin
          state_r       <= IDLE;
          sel_r         <= '0;
          grant_valid_r <= 1'b0;
          owner_r       <= '0;
          tenure_r      <= 8'd0;
          capture_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_lines     = sel_r;
  assign bus.grant_valid   = grant_valid_r;
  assign bus.owner_id      = owner_r;
  assign bus.bus_data_q    = data_r;
  assign bus.capture_valid = capture_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run, all compared each cycle against a behavioural arbitration model.
module tb_bus_arbiter;

  localparam int L   = 4;
  localparam int W   = 32;
  localparam int MH  = 4;
  localparam int IW  = bus_pkg::id_width(L);
  localparam int OBS = L + 1 + IW + W + 1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic signed [W-1:0] drv [L];

  bus_arbiter_if #(.Bus_length(L), .Bus_width(W)) bus ();

  bus_arbiter #(.Bus_length(L), .Bus_width(W), .Max_hold(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bus_arbiter_chk #(.N(L)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .sel_lines (bus.sel_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resolved bus: the enabled driver's value, wired-OR of enabled drivers
  always_comb begin
    bus.bus_in = '0;
    for (int i = 0; i < L; i++) begin
      if (bus.sel_lines[i]) bus.bus_in = bus.bus_in | drv[i];
    end
  end

  // ---------------- behavioural reference model ----------------
  // owner = -1 when nobody holds the bus; count = cycles owned so far.
  int                  m_owner = -1;
  int                  m_count = 0;
  int                  m_last  = L - 1;
  int                  m_cand;
  logic signed [W-1:0] m_data  = '0;
  logic                m_cap   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_count = 0; m_last = L - 1; m_data = '0; m_cap = 1'b0;
    end else if (m_owner < 0) begin
      m_cap = 1'b0;
      for (int k = 1; k <= L; k++) begin
        m_cand = (m_last + k) % L;
        if (m_owner < 0 && bus.req[m_cand]) begin
          m_owner = m_cand; m_last = m_cand; m_count = 1;
        end
      end
    end else begin
      m_data = drv[m_owner];
      m_cap  = 1'b1;
      if (bus.req[m_owner] && m_count < MH) m_count = m_count + 1;
      else begin m_owner = -1; m_count = 0; end
    end
  end

  logic [OBS-1:0] obs;
  logic [OBS-1:0] exp_v;
  logic [L-1:0]   m_sel;
  logic [IW-1:0]  m_id;

  assign obs = {bus.sel_lines, bus.grant_valid, bus.owner_id, bus.bus_data_q, bus.capture_valid};

  always_comb begin
    m_sel = '0;
    m_id  = '0;
    if (m_owner >= 0) begin
      m_sel = L'(1) << m_owner;
      m_id  = IW'(m_owner);
    end
    exp_v = {m_sel, (m_owner >= 0), m_id, m_data, m_cap};
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.req = '0;
    for (int i = 0; i < L; i++) drv[i] = '0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", obs);
    end
  endtask

  task automatic test_single();
    drv[0] = 32'sd13;
    rst = 1'b0; bus.req = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (bus.sel_lines !== 4'b0001 || bus.grant_valid !== 1'b1 || bus.owner_id !== 2'd0) begin
      n_fail++; $display("FAIL single_grant: sel=%b gv=%b id=%0d want 0001/1/0", bus.sel_lines, bus.grant_valid, bus.owner_id);
    end
    n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL single_model c1: got %h want %h", obs, exp_v); end
    bus.req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (bus.bus_data_q !== 32'sd13 || bus.capture_valid !== 1'b1 || bus.sel_lines !== 4'b0000) begin
      n_fail++; $display("FAIL single_capture: q=%0d cap=%b sel=%b want 13/1/0000", bus.bus_data_q, bus.capture_valid, bus.sel_lines);
    end
    @(negedge clk);
    n_tests++;
    if (bus.capture_valid !== 1'b0 || bus.sel_lines !== 4'b0000) begin
      n_fail++; $display("FAIL single_idle: cap=%b sel=%b want 0/0000", bus.capture_valid, bus.sel_lines);
    end
  endtask

  task automatic test_rotation();
    int own;
    int p;
    drv[0] = 32'sd13; drv[1] = 32'sd3; drv[2] = 32'sd2432; drv[3] = 32'sd31123;
    rst = 1'b1; bus.req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      p   = (k - 1) % 5;
      own = ((k - 1) / 5) % 4;
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rotation_model c%0d: got %h want %h", k, obs, exp_v); end
      n_tests++;
      if (bus.sel_lines !== ((p < 4) ? (4'b0001 << own) : 4'b0000)) begin
        n_fail++; $display("FAIL rotation_sel c%0d: got %b want owner %0d phase %0d", k, bus.sel_lines, own, p);
      end
      if (p >= 1) begin
        n_tests++;
        if (bus.bus_data_q !== drv[own] || bus.capture_valid !== 1'b1) begin
          n_fail++; $display("FAIL rotation_data c%0d: q=%0d cap=%b want %0d/1", k, bus.bus_data_q, bus.capture_valid, drv[own]);
        end
      end
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rotation_drain c%0d: got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_pulse();
    bus.req = 4'b0100;
    @(negedge clk);
    n_tests++;
    if (bus.sel_lines !== 4'b0100 || bus.owner_id !== 2'd2) begin
      n_fail++; $display("FAIL pulse_grant: sel=%b id=%0d want 0100/2", bus.sel_lines, bus.owner_id);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (bus.sel_lines !== 4'b0000 || bus.bus_data_q !== 32'sd2432 || bus.capture_valid !== 1'b1) begin
      n_fail++; $display("FAIL pulse_capture: sel=%b q=%0d cap=%b want 0000/2432/1", bus.sel_lines, bus.bus_data_q, bus.capture_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.sel_lines !== 4'b0000 || bus.capture_valid !== 1'b0) begin
      n_fail++; $display("FAIL pulse_idle: sel=%b cap=%b want 0000/0", bus.sel_lines, bus.capture_valid);
    end
  endtask

  task automatic test_regrant();
    int p;
    bus.req = 4'b1000;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      p = (k - 1) % 5;
      n_tests++;
      if (bus.sel_lines !== ((p < 4) ? 4'b1000 : 4'b0000)) begin
        n_fail++; $display("FAIL regrant_sel c%0d: got %b phase %0d", k, bus.sel_lines, p);
      end
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL regrant_model c%0d: got %h want %h", k, obs, exp_v); end
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL regrant_drain c%0d: got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    drv[1] = 32'sd3;
    bus.req = 4'b0010;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (bus.sel_lines !== 4'b0010) begin
      n_fail++; $display("FAIL midrst_hold: sel=%b want 0010", bus.sel_lines);
    end
    rst = 1'b1; bus.req = 4'b0111;
    @(negedge clk);
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL midrst_clear: got %h want 0", obs); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.sel_lines !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_first: sel=%b want 0001", bus.sel_lines);
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_drain c%0d: got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (k % 25 == 0) begin
        for (int i = 0; i < L; i++) drv[i] = $signed($urandom);
      end
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random_model c%0d: got %h want %h", k, obs, exp_v); end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.req = '0;
    test_reset();
    test_single();
    test_rotation();
    test_pulse();
    test_regrant();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
